// File: rtl/zap_fetch_prefetch_queue.sv
// Instruction prefetch queue between fetch and the decode sequencing FSM.
// Buffers {instruction, pc} entries, holds the head stable under stall,
// and flushes on pipeline clears. o_ready depends on registered state only.
module zap_fetch_prefetch_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic [34:0]               i_instruction,
    input  logic                      i_instruction_valid,
    input  logic [31:0]               i_pc,
    output logic                      o_ready,
    input  logic                      i_irq,
    input  logic                      i_fiq,
    input  logic                      i_clear_from_writeback,
    input  logic                      i_data_stall,
    input  logic                      i_clear_from_alu,
    input  logic                      i_stall_from_shifter,
    input  logic                      i_issue_stall,
    input  logic                      i_stall_from_decode,
    output logic [34:0]               o_instruction,
    output logic                      o_instruction_valid,
    output logic [31:0]               o_pc,
    output logic                      o_irq,
    output logic                      o_fiq,
    output logic [$clog2(DEPTH):0]    o_level
);

    localparam int unsigned IdxW   = $clog2(DEPTH);
    localparam int unsigned PtrW   = IdxW + 1;
    localparam int unsigned EntryW = 35 + 32;

    logic [EntryW-1:0] mem [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;

    logic full, empty, hold, push, pop, mem_we;
    logic [EntryW-1:0] head;

    // Occupancy flags from registered pointers only (extra MSB is the wrap bit).
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                   (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);

    assign hold = i_data_stall | i_stall_from_shifter | i_issue_stall | i_stall_from_decode;
    assign push = i_instruction_valid & ~full;
    assign pop  = ~empty & ~hold;

    // Next pointer state; clear/stall priority mirrors the decode FSM.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_we   = 1'b0;
        if (i_clear_from_writeback) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else if (i_data_stall) begin
            // Memory stall blocks the pop but fetch may still fill the queue.
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                mem_we   = 1'b1;
            end
        end else if (i_clear_from_alu) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                mem_we   = 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    // Pointer registers; reset empties the queue immediately.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are don't-care outside the valid window.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[wr_ptr_q[IdxW-1:0]] <= {i_instruction, i_pc};
        end
    end

    // Head outputs and interrupt gating.
    always_comb begin
        head                = mem[rd_ptr_q[IdxW-1:0]];
        o_instruction_valid = ~empty;
        o_instruction       = empty ? 35'd0 : head[EntryW-1:32];
        o_pc                = empty ? 32'd0 : head[31:0];
        o_ready             = ~full;
        o_level             = wr_ptr_q - rd_ptr_q;
        o_irq               = i_irq & ~empty;
        o_fiq               = i_fiq & ~empty;
    end

endmodule

// File: tb/tb_zap_fetch_prefetch_queue.sv
// Directed self-checking bench for zap_fetch_prefetch_queue (DEPTH = 4).
module tb_zap_fetch_prefetch_queue;

    logic        clk;
    logic        rst_n;
    logic [34:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic        ready;
    logic        irq, fiq;
    logic        clr_wb, data_stall, clr_alu, stall_shift, issue_stall, stall_dec;
    logic [34:0] o_instr;
    logic        o_valid;
    logic [31:0] o_pc;
    logic        o_irq, o_fiq;
    logic [2:0]  level;

    int errors = 0;
    int checks = 0;

    zap_fetch_prefetch_queue #(.DEPTH(4)) dut (
        .i_clk                  (clk),
        .i_reset_n              (rst_n),
        .i_instruction          (instr),
        .i_instruction_valid    (instr_valid),
        .i_pc                   (pc),
        .o_ready                (ready),
        .i_irq                  (irq),
        .i_fiq                  (fiq),
        .i_clear_from_writeback (clr_wb),
        .i_data_stall           (data_stall),
        .i_clear_from_alu       (clr_alu),
        .i_stall_from_shifter   (stall_shift),
        .i_issue_stall          (issue_stall),
        .i_stall_from_decode    (stall_dec),
        .o_instruction          (o_instr),
        .o_instruction_valid    (o_valid),
        .o_pc                   (o_pc),
        .o_irq                  (o_irq),
        .o_fiq                  (o_fiq),
        .o_level                (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [34:0] ins, input logic [31:0] p);
        instr_valid = v;
        instr       = ins;
        pc          = p;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 35'd0, 32'd0);
        irq = 0; fiq = 0; clr_wb = 0; data_stall = 0; clr_alu = 0;
        stall_shift = 0; issue_stall = 0; stall_dec = 0;

        // Reset state
        #2;
        check("rst_level", 64'(level), 64'd0);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_instr", 64'(o_instr), 64'd0);
        check("rst_pc",    64'(o_pc), 64'd0);
        check("rst_irq",   64'(o_irq), 64'd0);
        step();
        rst_n = 1'b1;

        // Fill under decode stall: head must stay at the first entry
        stall_dec = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 35'h0E1A0001 + 35'(i), 32'(4 * i));
            step();
            check("fill_level", 64'(level), 64'(i + 1));
            check("fill_head",  64'(o_instr), 64'h0E1A0001);
            check("fill_pc",    64'(o_pc), 64'h0);
        end
        check("fill_ready", 64'(ready), 64'd0);

        // Drain in order, one per cycle
        drive(1'b0, 35'd0, 32'd0);
        stall_dec = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("drain_head", 64'(o_instr), 64'h0E1A0001 + 64'(k));
            check("drain_pc",   64'(o_pc), 64'(4 * k));
            step();
        end
        check("drain_valid", 64'(o_valid), 64'd0);
        check("drain_instr", 64'(o_instr), 64'd0);
        check("drain_level", 64'(level), 64'd0);

        // Sustained push+pop at level 2 across pointer wrap
        stall_dec = 1'b1;
        drive(1'b1, 35'h0E1B0000, 32'h100);
        step();
        drive(1'b1, 35'h0E1B0001, 32'h104);
        step();
        check("pp_start_level", 64'(level), 64'd2);
        stall_dec = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("pp_head", 64'(o_instr), 64'h0E1B0000 + 64'(k));
            check("pp_pc",   64'(o_pc), 64'h100 + 64'(4 * k));
            drive(1'b1, 35'h0E1B0000 + 35'(k + 2), 32'h100 + 32'(4 * (k + 2)));
            step();
            check("pp_level", 64'(level), 64'd2);
        end
        // Queue now holds B10, B11

        // Full + pop: push refused while full even though a pop happens
        stall_dec = 1'b1;
        drive(1'b1, 35'h0E1B000C, 32'h130);
        step();
        drive(1'b1, 35'h0E1B000D, 32'h134);
        step();
        check("full_level", 64'(level), 64'd4);
        stall_dec = 1'b0;
        drive(1'b1, 35'h0E1B000E, 32'h138);
        check("full_ready", 64'(ready), 64'd0);
        step();
        check("fp_level1", 64'(level), 64'd3);
        check("fp_ready1", 64'(ready), 64'd1);
        check("fp_head1",  64'(o_instr), 64'h0E1B000B);
        step();
        check("fp_level2", 64'(level), 64'd3);
        check("fp_head2",  64'(o_instr), 64'h0E1B000C);
        drive(1'b0, 35'd0, 32'd0);
        stall_dec = 1'b1;
        // Queue now holds B12, B13, B14

        // Clear from ALU is overridden by data stall
        clr_alu = 1'b1;
        data_stall = 1'b1;
        step();
        check("alu_ds_level", 64'(level), 64'd3);
        check("alu_ds_head",  64'(o_instr), 64'h0E1B000C);

        // Clear from ALU alone flushes and discards the concurrent push
        data_stall = 1'b0;
        stall_dec = 1'b0;
        drive(1'b1, 35'h0DEAD, 32'h200);
        step();
        check("alu_level", 64'(level), 64'd0);
        check("alu_valid", 64'(o_valid), 64'd0);
        check("alu_ready", 64'(ready), 64'd1);
        check("alu_instr", 64'(o_instr), 64'd0);
        clr_alu = 1'b0;
        drive(1'b0, 35'd0, 32'd0);
        step();
        check("alu_after_level", 64'(level), 64'd0);

        // Data stall alone: pop blocked, push accepted
        stall_dec = 1'b1;
        drive(1'b1, 35'h0E1C0000, 32'h300);
        step();
        drive(1'b1, 35'h0E1C0001, 32'h304);
        step();
        stall_dec = 1'b0;
        data_stall = 1'b1;
        drive(1'b1, 35'h0E1C0002, 32'h308);
        step();
        check("ds_level", 64'(level), 64'd3);
        check("ds_head",  64'(o_instr), 64'h0E1C0000);

        // Writeback clear wins over data stall
        clr_wb = 1'b1;
        drive(1'b1, 35'h0E1C0003, 32'h30C);
        step();
        check("wb_level", 64'(level), 64'd0);
        check("wb_valid", 64'(o_valid), 64'd0);
        clr_wb = 1'b0;
        data_stall = 1'b0;
        drive(1'b0, 35'd0, 32'd0);
        step();
        check("wb_after_level", 64'(level), 64'd0);

        // Interrupt gating
        irq = 1'b1;
        fiq = 1'b1;
        #1;
        check("irq_empty", 64'(o_irq), 64'd0);
        check("fiq_empty", 64'(o_fiq), 64'd0);
        stall_dec = 1'b1;
        drive(1'b1, 35'h0E1D0000, 32'h400);
        step();
        check("irq_one", 64'(o_irq), 64'd1);
        check("fiq_one", 64'(o_fiq), 64'd1);
        drive(1'b1, 35'h0E1D0001, 32'h404);
        step();
        drive(1'b0, 35'd0, 32'd0);
        check("pre_rst_level", 64'(level), 64'd2);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(o_valid), 64'd0);
        check("arst_irq",   64'(o_irq), 64'd0);
        check("arst_level", 64'(level), 64'd0);
        check("arst_ready", 64'(ready), 64'd1);
        step();
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
